// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arith/shift ops and a W-cycle shift-add multiplier
//   clk        : rising-edge clock
//   resetN     : asynchronous active-low reset
//   start      : begin an operation (sampled only while busy=0)
//   operation  : operation code (0 AND,1 OR,2 XOR,3 ADD,4 SUB,5 SHL,6 SHR,7 MUL)
//   operandA/B : operands, sampled with start
//   result     : registered low result word
//   resultHigh : registered high product word (MUL only, else 0)
//   flags      : registered {N, V, C, Z}
//   busy       : multiplier in progress
//   done       : one-cycle pulse per completed operation
//   opError    : last completed operation code was undefined
`ifndef MEMORY_WORD_SIZE
`define MEMORY_WORD_SIZE 8
`endif
module alu_seq #(
   parameter int MEMORY_WORD_SIZE = `MEMORY_WORD_SIZE,
   parameter int OPERATOR_SIZE = 4
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          start,
   input  logic [OPERATOR_SIZE-1:0]      operation,
   input  logic [MEMORY_WORD_SIZE-1:0]   operandA,
   input  logic [MEMORY_WORD_SIZE-1:0]   operandB,
   output logic [MEMORY_WORD_SIZE-1:0]   result,
   output logic [MEMORY_WORD_SIZE-1:0]   resultHigh,
   output logic [3:0]                    flags,
   output logic                          busy,
   output logic                          done,
   output logic                          opError
);
   localparam int W = MEMORY_WORD_SIZE;
   localparam int SW = $clog2(W);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL = 1'b1;
   localparam logic [OPERATOR_SIZE-1:0] OP_AND = OPERATOR_SIZE'(0);
   localparam logic [OPERATOR_SIZE-1:0] OP_OR = OPERATOR_SIZE'(1);
   localparam logic [OPERATOR_SIZE-1:0] OP_XOR = OPERATOR_SIZE'(2);
   localparam logic [OPERATOR_SIZE-1:0] OP_ADD = OPERATOR_SIZE'(3);
   localparam logic [OPERATOR_SIZE-1:0] OP_SUB = OPERATOR_SIZE'(4);
   localparam logic [OPERATOR_SIZE-1:0] OP_SHL = OPERATOR_SIZE'(5);
   localparam logic [OPERATOR_SIZE-1:0] OP_SHR = OPERATOR_SIZE'(6);
   localparam logic [OPERATOR_SIZE-1:0] OP_MUL = OPERATOR_SIZE'(7);

   logic [0:0]     state_q, state_d;
   logic [W-1:0]   res_q, res_d, hi_q, hi_d, mcand_q, mcand_d;
   logic [3:0]     flags_q, flags_d;
   logic           done_q, done_d, err_q, err_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [SW-1:0]  cnt_q, cnt_d;

   logic [SW-1:0]  amt;
   logic [W:0]     add_w, sub_w, shl_w, shr_w, psum;
   logic [2*W-1:0] step;
   logic [W-1:0]   alu_r;
   logic           alu_c, alu_v, alu_bad;

   assign amt = operandB[SW-1:0];
   assign add_w = {1'b0, operandA} + {1'b0, operandB};
   // bit W of the widened difference is the borrow (A < B unsigned)
   assign sub_w = {1'b0, operandA} - {1'b0, operandB};
   // the extra bit beside each shift catches the last bit shifted out; it is 0 for amt=0
   assign shl_w = {1'b0, operandA} << amt;
   assign shr_w = {operandA, 1'b0} >> amt;

   // one shift-add step: high half accumulates the multiplicand when the current
   // multiplier bit (prod_q[0]) is set, then the whole product shifts right
   assign psum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
   assign step = {psum, prod_q[W-1:1]};

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      alu_bad = 1'b0;
      case (operation)
         OP_AND: alu_r = operandA & operandB;
         OP_OR:  alu_r = operandA | operandB;
         OP_XOR: alu_r = operandA ^ operandB;
         OP_ADD: begin
            alu_r = add_w[W-1:0];
            alu_c = add_w[W];
            alu_v = (operandA[W-1] == operandB[W-1]) && (add_w[W-1] != operandA[W-1]);
         end
         OP_SUB: begin
            alu_r = sub_w[W-1:0];
            alu_c = sub_w[W];
            alu_v = (operandA[W-1] != operandB[W-1]) && (sub_w[W-1] != operandA[W-1]);
         end
         OP_SHL: begin
            alu_r = shl_w[W-1:0];
            alu_c = shl_w[W];
         end
         OP_SHR: begin
            alu_r = shr_w[W:1];
            alu_c = shr_w[0];
         end
         default: alu_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      res_d = res_q;
      hi_d = hi_q;
      flags_d = flags_q;
      err_d = err_q;
      done_d = 1'b0;
      mcand_d = mcand_q;
      prod_d = prod_q;
      cnt_d = cnt_q;
      if (state_q == S_MUL) begin
         prod_d = step;
         cnt_d = cnt_q + SW'(1);
         if (cnt_q == SW'(W - 1)) begin
            state_d = S_IDLE;
            res_d = step[W-1:0];
            hi_d = step[2*W-1:W];
            flags_d = {step[W-1], |step[2*W-1:W], 1'b0, ~|step};
            err_d = 1'b0;
            done_d = 1'b1;
            cnt_d = '0;
         end
      end else if (start) begin
         if (operation == OP_MUL) begin
            state_d = S_MUL;
            mcand_d = operandA;
            prod_d = {{W{1'b0}}, operandB};
            cnt_d = '0;
         end else begin
            res_d = alu_r;
            hi_d = '0;
            flags_d = {alu_r[W-1], alu_v, alu_c, ~|alu_r};
            err_d = alu_bad;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_IDLE;
         res_q <= '0;
         hi_q <= '0;
         flags_q <= '0;
         err_q <= 1'b0;
         done_q <= 1'b0;
         mcand_q <= '0;
         prod_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         res_q <= res_d;
         hi_q <= hi_d;
         flags_q <= flags_d;
         err_q <= err_d;
         done_q <= done_d;
         mcand_q <= mcand_d;
         prod_q <= prod_d;
         cnt_q <= cnt_d;
      end
   end

   assign result = res_q;
   assign resultHigh = hi_q;
   assign flags = flags_q;
   assign busy = (state_q == S_MUL);
   assign done = done_q;
   assign opError = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (W=8) against an arithmetic reference model
module tb_alu_seq;
   logic       clk = 1'b0;
   logic       resetN;
   logic       start;
   logic [3:0] operation;
   logic [7:0] operandA, operandB;
   logic [7:0] result, resultHigh;
   logic [3:0] flags;
   logic       busy, done, opError;

   int total = 0;
   int bad = 0;
   int exp_r = 0, exp_h = 0, exp_f = 0, exp_e = 0;

   alu_seq dut (
      .clk(clk), .resetN(resetN), .start(start), .operation(operation),
      .operandA(operandA), .operandB(operandB), .result(result),
      .resultHigh(resultHigh), .flags(flags), .busy(busy), .done(done),
      .opError(opError)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: plain integer arithmetic on 8-bit operands
   task automatic ref_model(input int op, input int a, input int b);
      int sa, sb, r, c, v, z, n, p;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      c = 0;
      v = 0;
      exp_h = 0;
      exp_e = 0;
      p = a * b;
      case (op)
         0: r = a & b;
         1: r = a | b;
         2: r = a ^ b;
         3: begin
            r = (a + b) % 256;
            c = (a + b > 255) ? 1 : 0;
            v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
         end
         4: begin
            r = (a - b + 256) % 256;
            c = (a < b) ? 1 : 0;
            v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
         end
         5: begin
            n = b % 8;
            r = (a << n) % 256;
            c = (n != 0) ? (a >> (8 - n)) % 2 : 0;
         end
         6: begin
            n = b % 8;
            r = a >> n;
            c = (n != 0) ? (a >> (n - 1)) % 2 : 0;
         end
         7: begin
            r = p % 256;
            exp_h = p / 256;
            v = (exp_h != 0) ? 1 : 0;
         end
         default: begin
            r = 0;
            exp_e = 1;
         end
      endcase
      z = (op == 7) ? ((p == 0) ? 1 : 0) : ((r == 0) ? 1 : 0);
      exp_r = r;
      exp_f = ((r > 127) ? 8 : 0) + v * 4 + c * 2 + z;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_res"}, result, exp_r);
      chk({tag, "_hi"}, resultHigh, exp_h);
      chk({tag, "_flags"}, flags, exp_f);
      chk({tag, "_err"}, opError, exp_e);
   endtask

   // called at a negedge; returns at the negedge where the result is visible
   task automatic issue(input int op, input int a, input int b);
      logic [31:0] opv, av, bv;
      opv = op;
      av = a;
      bv = b;
      start = 1'b1;
      operation = opv[3:0];
      operandA = av[7:0];
      operandB = bv[7:0];
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (op == 7) begin
         for (int i = 0; i < 8; i++) begin
            chk("mul_busy", busy, 1);
            chk("mul_done_low", done, 0);
            chk("mul_hold_res", result, exp_r);
            start = 1'($urandom);
            operation = 4'($urandom);
            operandA = 8'($urandom);
            operandB = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
         end
         start = 1'b0;
      end
      ref_model(op, a, b);
      chk("op_done", done, 1);
      chk("op_busy_low", busy, 0);
      check_outputs("op");
   endtask

   task automatic idle();
      start = 1'b0;
      operation = 4'($urandom);
      operandA = 8'($urandom);
      operandB = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      check_outputs("idle");
   endtask

   initial begin
      resetN = 1'b0;
      start = 1'b0;
      operation = '0;
      operandA = '0;
      operandB = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_res", result, 0);
      chk("rst_hi", resultHigh, 0);
      chk("rst_flags", flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", opError, 0);
      resetN = 1'b1;

      issue(3, 'h7F, 'h01);
      chk("add7f_res", result, 'h80);
      chk("add7f_flags", flags, 4'b1100);
      idle();
      issue(4, 'h10, 'h20);
      chk("sub_borrow_res", result, 'hF0);
      chk("sub_borrow_flags", flags, 4'b1010);
      issue(4, 'h55, 'h55);
      chk("sub_zero_flags", flags, 4'b0001);
      issue(5, 'h81, 1);
      chk("shl_res", result, 'h02);
      chk("shl_flags", flags, 4'b0010);
      issue(6, 'h01, 0);
      chk("shr0_res", result, 'h01);
      chk("shr0_flags", flags, 4'b0000);
      issue('hC, 'h12, 'h34);
      chk("undef_flags", flags, 4'b0001);
      chk("undef_err", opError, 1);
      issue(0, 'hF0, 'h3C);
      chk("and_res", result, 'h30);
      chk("and_err", opError, 0);
      issue(7, 'hFF, 'hFF);
      chk("mul_lo", result, 'h01);
      chk("mul_hi", resultHigh, 'hFE);
      chk("mul_flags", flags, 4'b0100);
      idle();

      // reset in the fourth busy cycle of a multiply
      start = 1'b1;
      operation = 4'd7;
      operandA = 8'hA5;
      operandB = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 resetN = 1'b0;
      #1;
      chk("arst_res", result, 0);
      chk("arst_hi", resultHigh, 0);
      chk("arst_flags", flags, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_err", opError, 0);
      exp_r = 0;
      exp_h = 0;
      exp_f = 0;
      exp_e = 0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_hold_done", done, 0);
      resetN = 1'b1;
      issue(3, 'h20, 'h22);
      chk("post_rst_add", result, 'h42);
      for (int i = 0; i < 10; i++) idle();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) idle();
         else issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
